dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
- Parametrised, blocking, direct-mapped, write-back / write-allocate data cache.
- Sits between the core's memory-access stage and a word-serial backing-memory port.
- Replaces the ideal single-cycle data memory with real hit/miss timing, dirty eviction and an explicit flush.
- Keeps the core-side width/sign-extension semantics: byte/half/word, zero- or sign-extended loads.

Parameters:
LINES, 64, number of cache lines; power of two, >= 2.
WORDS, 4, 32-bit words per line; power of two, >= 1.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  core request valid.
req_ready  out  1  cache accepts a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_width  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_ext  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  one-cycle pulse: response ready.
resp_rdata  out  32  load result, extended; 0 for stores and errors.
resp_err  out  1  qualifies resp_valid: misaligned access or width 3.
flush  in  1  request write-back and invalidation of all lines.
flush_done  out  1  one-cycle pulse: flush complete.
mem_req  out  1  memory word transfer request.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  word-aligned memory address.
mem_wdata  out  32  memory write data.
mem_ack  in  1  transfer complete; mem_rdata valid this cycle for reads.
mem_rdata  in  32  memory read data.

Behaviour:
- Address split:
  - offset = 2 + log2(WORDS) bits.
  - index = log2(LINES) bits.
  - tag = remaining upper bits.
- Storage per line: valid, dirty, tag, WORDS x 32 data.
- Reset (rst_n low, asynchronous):
  - all valid/dirty bits cleared; state = IDLE.
  - req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, flush_done = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset mid-transfer abandons it; no data is written.
- States: IDLE, LOOKUP, EVICT, REFILL, FLUSH.
- req_ready = 1 only in IDLE. In IDLE with req_valid, the request is latched and the FSM goes to LOOKUP.
- flush is sampled only in IDLE with req_valid low; a simultaneous req_valid has priority and flush stays pending until taken.
- LOOKUP:
  - Misaligned access (half with addr[0] set, word with addr[1:0] != 0) or width 3: resp_valid = resp_err = 1, no state change, back to IDLE.
  - Hit (valid and tag equal): load returns the extracted, extended lane; store merges the byte/half/word lane into the line and sets dirty. resp_valid pulses; back to IDLE.
  - Hit latency: request accepted at cycle N, resp_valid at N+2 (N+1 = LOOKUP register stage, response asserted on leaving LOOKUP). Peak throughput is one access per 2 cycles.
  - Miss with a valid, dirty victim: go to EVICT. Otherwise go to REFILL.
- EVICT:
  - Writes WORDS words at {old_tag, index, w, 2'b00}, w = 0..WORDS-1 ascending.
  - mem_req/mem_we held with stable addr/wdata until mem_ack; the next word is presented the cycle after ack.
  - After the last ack: go to REFILL.
- REFILL:
  - Reads WORDS words at {new_tag, index, w, 2'b00}, ascending, capturing mem_rdata on mem_ack.
  - After the last ack: valid = 1, dirty = 0, tag updated; return to LOOKUP, which now hits.
- FLUSH:
  - Scans index 0..LINES-1; each valid, dirty line is written back as in EVICT.
  - Every line is invalidated.
  - flush_done pulses the cycle the FSM returns to IDLE. A flush on a clean cache takes LINES cycles.
- mem_req drops for at least one cycle between the EVICT and REFILL phases.
- mem_ack while mem_req is low is ignored.
- Store lane merge:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - word: whole word.
- Load extension: sign bit of the selected lane when req_ext = 0, zeros when req_ext = 1.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, LOOKUP, EVICT, REFILL, FLUSH).
  - width codes W_BYTE = 0, W_HALF = 1, W_WORD = 2.
  - localparam functions for OFF_W, IDX_W, TAG_W.
- Sub-module dcache_lane: combinational store merge (old word, wdata, width, addr[1:0] -> new word) and load extract/extend (word, width, ext, addr[1:0] -> rdata). The same block is reused by the future icache refill path.

Test Plan:
- Cold load word at 0x10010000, memory holds 0x11111111..0x44444444 at 0x10010000..0x1001000C, ack after 2 cycles each -> 4 reads ascending; resp_rdata = 0x11111111. A repeat load gives resp_valid 2 cycles after accept, with no mem_req.
- Store byte 0x80 to 0x10010001 on a hit line, then LB and LBU from the same address -> 0xFFFFFF80 and 0x00000080; line dirty; no memory traffic.
- After the dirty store, load an address with the same index and a different tag (0x10010000 + LINES*WORDS*4) -> 4 writes of the old line (word0 = 0x11118011) then 4 reads; correct new data returned.
- LH at 0x10010003 and LW at 0x10010002 -> resp_err = 1, resp_rdata = 0, no state or memory change.
- flush with 2 dirty lines -> exactly 8 writes at the correct addresses; flush_done pulses once; the next access to those lines misses.
- rst_n low during the 3rd REFILL ack wait -> mem_req = 0 immediately; after release the line is invalid and the next load refills fully.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEvict,
        StRefill,
        StFlush
    } state_e;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    function automatic int unsigned off_w(input int unsigned words);
        return 2 + $clog2(words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                          input int unsigned words);
        return addr_w - off_w(words) - idx_w(lines);
    endfunction

endpackage

// File: rtl/dcache_lane.sv
// Byte/half/word lane handling: store merge into an existing word and load extract/extend.
module dcache_lane
    import dcache_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  width_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        ext_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
        merged_o = old_word_i;
        rdata_o  = old_word_i;
        case (width_i)
            W_BYTE: begin
                merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
                rdata_o = {{24{byte_sel[7] & ~ext_i}}, byte_sel};
            end
            W_HALF: begin
                merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                rdata_o = {{16{half_sel[15] & ~ext_i}}, half_sel};
            end
            W_WORD: merged_o = wdata_i;
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dcache_wb.sv
// Blocking direct-mapped write-back/write-allocate data cache with a word-serial memory port.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 64,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_width_i,
    input  logic              req_ext_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned OFF_W = off_w(WORDS);
    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = tag_w(ADDR_W, LINES, WORDS);
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e            state_q, state_d;
    logic              we_q, ext_q;
    logic [1:0]        width_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic              flush_pend_q, flush_pend_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              flush_done_q, flush_done_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [31:0]       data_q [LINES][WORDS];

    logic [IDX_W-1:0]  idx, vidx, vd_idx;
    logic [TAG_W-1:0]  tag;
    logic [CNT_W-1:0]  wsel, cnt_inc, issue_cnt, arr_wword;
    logic [31:0]       cur_word, merged, lane_rdata, arr_wdata;
    logic              hit, misalign, last, accept, issue, issue_we;
    logic              arr_we, tag_we, vd_we, valid_new, dirty_new;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_W-1:0] i,
                                                     input logic [CNT_W-1:0] w);
        return {t, i, {OFF_W{1'b0}}} | (ADDR_W'(w) << 2);
    endfunction

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign wsel     = (WORDS > 1) ? CNT_W'(addr_q >> 2) : '0;
    assign cur_word = data_q[idx][wsel];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign misalign = (width_q == 2'd3) || ((width_q == W_HALF) && addr_q[0]) ||
                      ((width_q == W_WORD) && (addr_q[1:0] != 2'b00));
    assign last     = (cnt_q == CNT_W'(WORDS - 1));
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign vidx     = (state_q == StFlush) ? fidx_q : idx;

    dcache_lane u_lane (
        .old_word_i (cur_word),
        .wdata_i    (wdata_q),
        .width_i    (width_q),
        .addr_lo_i  (addr_q[1:0]),
        .ext_i      (ext_q),
        .merged_o   (merged),
        .rdata_o    (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fidx_d       = fidx_q;
        flush_pend_d = flush_pend_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        accept       = 1'b0;
        issue        = 1'b0;
        issue_we     = 1'b0;
        issue_cnt    = cnt_q;
        arr_we       = 1'b0;
        arr_wword    = cnt_q;
        arr_wdata    = mem_rdata_i;
        tag_we       = 1'b0;
        vd_we        = 1'b0;
        vd_idx       = idx;
        valid_new    = 1'b0;
        dirty_new    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    accept       = 1'b1;
                    flush_pend_d = flush_pend_q | flush_i;
                    state_d      = StLookup;
                end else if (flush_i || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    fidx_d       = '0;
                    cnt_d        = '0;
                    state_d      = StFlush;
                end
            end
            StLookup: begin
                if (misalign) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = StIdle;
                end else if (hit) begin
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                    if (we_q) begin
                        arr_we    = 1'b1;
                        arr_wword = wsel;
                        arr_wdata = merged;
                        vd_we     = 1'b1;
                        valid_new = 1'b1;
                        dirty_new = 1'b1;
                    end else begin
                        resp_rdata_d = lane_rdata;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StEvict : StRefill;
                end
            end
            StEvict: begin
                issue_we = 1'b1;
                if (!mem_req_q) begin
                    issue = 1'b1;
                end else if (mem_ack_i) begin
                    if (last) begin
                        // Dropping mem_req here guarantees a bubble before the refill reads.
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = StRefill;
                    end else begin
                        cnt_d     = cnt_inc;
                        issue     = 1'b1;
                        issue_cnt = cnt_inc;
                    end
                end
            end
            StRefill: begin
                if (!mem_req_q) begin
                    issue = 1'b1;
                end else if (mem_ack_i) begin
                    arr_we = 1'b1;
                    if (last) begin
                        mem_req_d = 1'b0;
                        tag_we    = 1'b1;
                        vd_we     = 1'b1;
                        valid_new = 1'b1;
                        cnt_d     = '0;
                        state_d   = StLookup;
                    end else begin
                        cnt_d     = cnt_inc;
                        issue     = 1'b1;
                        issue_cnt = cnt_inc;
                    end
                end
            end
            StFlush: begin
                issue_we = 1'b1;
                vd_idx   = fidx_q;
                if (!mem_req_q && valid_q[fidx_q] && dirty_q[fidx_q]) begin
                    issue = 1'b1;
                end else if (!mem_req_q || (mem_ack_i && last)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                    vd_we     = 1'b1;
                    if (fidx_q == IDX_W'(LINES - 1)) begin
                        flush_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        fidx_d = fidx_q + IDX_W'(1);
                    end
                end else if (mem_ack_i) begin
                    cnt_d     = cnt_inc;
                    issue     = 1'b1;
                    issue_cnt = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            mem_req_d   = 1'b1;
            mem_we_d    = issue_we;
            mem_addr_d  = line_addr(issue_we ? tag_q[vidx] : tag, vidx, issue_cnt);
            mem_wdata_d = issue_we ? data_q[vidx][issue_cnt] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fidx_q       <= '0;
            flush_pend_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            we_q         <= 1'b0;
            ext_q        <= 1'b0;
            width_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fidx_q       <= fidx_d;
            flush_pend_q <= flush_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if (vd_we) begin
                valid_q[vd_idx] <= valid_new;
                dirty_q[vd_idx] <= dirty_new;
            end
            if (accept) begin
                we_q    <= req_we_i;
                ext_q   <= req_ext_i;
                width_q <= req_width_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    // Tag/data storage needs no reset: valid_q gates every use.
    always_ff @(posedge clk) begin
        if (arr_we) data_q[idx][arr_wword] <= arr_wdata;
        if (tag_we) tag_q[idx] <= tag;
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign flush_done_o = flush_done_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: hit vector table plus miss/evict/flush/reset sequences.
module tb_dcache_wb;

    localparam int unsigned LINES = 64;
    localparam int unsigned WORDS = 4;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_ext;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  req_width;
    logic        resp_valid, resp_err, flush, flush_done;
    logic        mem_req, mem_we, mem_ack;

    dcache_wb #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_width_i  (req_width),
        .req_ext_i    (req_ext),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  w;
        logic        ext;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_cnt = 0;
    int          gap_bad = 0;
    logic        prev_req = 1'b0;
    logic        prev_we = 1'b0;
    xfer_t       log_q[$];
    logic [31:0] mem [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // Memory model: acks on the second negedge of a pending request.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_req) begin
                wcnt++;
                if (wcnt >= 2) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                    log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (flush_done) fd_cnt <= fd_cnt + 1;
        if (mem_req && prev_req && (mem_we != prev_we)) gap_bad <= gap_bad + 1;
        prev_req <= mem_req;
        prev_we <= mem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] w,
                          input logic ext, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_width = w;
        req_ext = ext;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        err = resp_err;
        check("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic check_burst(input string name, input int start, input logic we,
                               input logic [31:0] base, input logic [31:0] d[4]);
        for (int i = 0; i < 4; i++) begin
            if (start + i < log_q.size()) begin
                check({name, "_we"}, {31'b0, log_q[start+i].we}, {31'b0, we});
                check({name, "_addr"}, log_q[start+i].addr, base + 32'(4 * i));
                check({name, "_data"}, log_q[start+i].data, d[i]);
            end else begin
                check({name, "_missing"}, log_q.size(), start + i + 1);
            end
        end
    endtask

    task automatic do_flush(output int edges);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        edges = 1;
        while (!flush_done && edges < 5000) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("flush_done_seen", {31'b0, flush_done}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd, d4[4];
        logic        err;
        int          lat, s, fd0, edges;

        vecs.push_back('{1'b0, 32'h1001_0004, 2'd2, 1'b0, 32'h0, 32'h2222_2222, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_000C, 2'd2, 1'b0, 32'h0, 32'h4444_4444, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0001, 2'd0, 1'b0, 32'h80, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0001, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0001, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0, 32'h1111_8011, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0003, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_0002, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_0000, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_0000, 2'd1, 1'b0, 32'h0, 32'hFFFF_8011, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0002, 2'd1, 1'b1, 32'h0, 32'h0000_1111, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0006, 2'd1, 1'b0, 32'h1234_ABCD, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0006, 2'd1, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0008, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0008, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_000B, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_000A, 2'd0, 1'b1, 32'h0, 32'h0000_00AD, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_000D, 2'd2, 1'b0, 32'h5555_5555, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_000C, 2'd2, 1'b0, 32'h0, 32'h4444_4444, 1'b0});

        mem[32'h1001_0000] = 32'h1111_1111;
        mem[32'h1001_0004] = 32'h2222_2222;
        mem[32'h1001_0008] = 32'h3333_3333;
        mem[32'h1001_000C] = 32'h4444_4444;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_width = '0;
        req_ext = 1'b0;
        req_wdata = '0;
        flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_outs", {27'b0, resp_valid, resp_err, flush_done, mem_req, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold load: four ascending reads.
        s = log_q.size();
        do_req(1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0, rd, err, lat);
        check("cold_rdata", rd, 32'h1111_1111);
        check("cold_nreads", log_q.size() - s, 32'd4);
        d4 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        check_burst("cold_rd", s, 1'b0, 32'h1001_0000, d4);
        s = log_q.size();
        do_req(1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0, rd, err, lat);
        check("rehit_lat", lat, 32'd2);
        check("rehit_rdata", rd, 32'h1111_1111);
        check("rehit_traffic", log_q.size() - s, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            s = log_q.size();
            do_req(vecs[i].we, vecs[i].addr, vecs[i].w, vecs[i].ext, vecs[i].wd, rd, err, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d_lat", i), lat, 32'd2);
            check($sformatf("vec%0d_traffic", i), log_q.size() - s, 32'd0);
        end

        // Conflict miss on a dirty line: write-back then refill.
        s = log_q.size();
        do_req(1'b0, 32'h1001_0400, 2'd2, 1'b0, 32'h0, rd, err, lat);
        check("evict_rdata", rd, ~32'h1001_0400);
        check("evict_nxfer", log_q.size() - s, 32'd8);
        d4 = '{32'h1111_8011, 32'hABCD_2222, 32'hDEAD_BEEF, 32'h4444_4444};
        check_burst("evict_wr", s, 1'b1, 32'h1001_0000, d4);
        d4 = '{~32'h1001_0400, ~32'h1001_0404, ~32'h1001_0408, ~32'h1001_040C};
        check_burst("evict_rd", s + 4, 1'b0, 32'h1001_0400, d4);

        // Two dirty lines, then flush.
        do_req(1'b1, 32'h1001_0400, 2'd2, 1'b0, 32'hCAFE_F00D, rd, err, lat);
        check("dirty0_lat", lat, 32'd2);
        do_req(1'b1, 32'h1001_0010, 2'd2, 1'b0, 32'h0BAD_C0DE, rd, err, lat);
        check("dirty1_err", {31'b0, err}, 32'd0);
        s = log_q.size();
        fd0 = fd_cnt;
        do_flush(edges);
        check("flush_nxfer", log_q.size() - s, 32'd8);
        d4 = '{32'hCAFE_F00D, ~32'h1001_0404, ~32'h1001_0408, ~32'h1001_040C};
        check_burst("flush_l0", s, 1'b1, 32'h1001_0400, d4);
        d4 = '{32'h0BAD_C0DE, ~32'h1001_0014, ~32'h1001_0018, ~32'h1001_001C};
        check_burst("flush_l1", s + 4, 1'b1, 32'h1001_0010, d4);
        @(posedge clk);
        #1;
        check("flush_done_pulses", fd_cnt - fd0, 32'd1);
        s = log_q.size();
        do_req(1'b0, 32'h1001_0010, 2'd2, 1'b0, 32'h0, rd, err, lat);
        check("postflush_rdata", rd, 32'h0BAD_C0DE);
        check("postflush_nreads", log_q.size() - s, 32'd4);

        // Flushing a cache with no dirty lines: one cycle per line, no traffic.
        s = log_q.size();
        fd0 = fd_cnt;
        do_flush(edges);
        check("clean_flush_edges", edges, LINES + 1);
        check("clean_flush_traffic", log_q.size() - s, 32'd0);
        @(posedge clk);
        #1;
        check("clean_flush_pulses", fd_cnt - fd0, 32'd1);

        // Reset while the third refill word is outstanding.
        s = log_q.size();
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h1001_0800;
        req_width = 2'd2;
        req_ext = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 0;
        while (!(log_q.size() - s == 2 && mem_req && !mem_ack && mem_addr == 32'h1001_0808)
               && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("rst3_reached", mem_addr, 32'h1001_0808);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst3_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst3_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s = log_q.size();
        do_req(1'b0, 32'h1001_0800, 2'd2, 1'b0, 32'h0, rd, err, lat);
        check("rst3_rdata", rd, ~32'h1001_0800);
        check("rst3_nreads", log_q.size() - s, 32'd4);
        d4 = '{~32'h1001_0800, ~32'h1001_0804, ~32'h1001_0808, ~32'h1001_080C};
        check_burst("rst3_rd", s, 1'b0, 32'h1001_0800, d4);
        check("evict_refill_gap", gap_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
